sys_update_ctrl: RTL and testbench

- Initiator/controller for the remote system-update IP (Altera remote-update style: busy/param/read_param/write_param/reconfig/reset_timer).
- Accepts single commands from the CPU-side register block: read a parameter, write a parameter, trigger reconfiguration, or kick the watchdog.
- Sequences the IP handshake, enforces a timeout and returns read data and status.
- Sits between the system register file and the update IP instance.

---
 rtl/sys_update_pkg.sv | 25 ++
 rtl/sys_update_ctrl.sv | 128 ++++++++++++
 tb/tb_sys_update_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sys_update_pkg.sv
// Shared types for the remote system-update controller: command opcodes,
// parameter selects for the update IP and the controller FSM states.
package sys_update_pkg;

    typedef enum logic [1:0] {
        OP_RD    = 2'd0,
        OP_WR    = 2'd1,
        OP_RECFG = 2'd2,
        OP_KICK  = 2'd3
    } op_e;

    localparam logic [2:0] PRM_STATUS    = 3'h0;
    localparam logic [2:0] PRM_WDT_TO    = 3'h2;
    localparam logic [2:0] PRM_WDT_EN    = 3'h3;
    localparam logic [2:0] PRM_BOOT_ADDR = 3'h4;
    localparam logic [2:0] PRM_CFG_MODE  = 3'h5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/sys_update_ctrl.sv
// Single-command initiator for the remote-update IP; 4 cycles accept-to-rsp_valid when idle IP (2 for a kick).
// One command in flight: cmd_ready stays low from accept until the cycle after the response pulse.
module sys_update_ctrl #(
    parameter int MIN_WAIT = 2,
    parameter int TIMEOUT  = 4096,
    parameter int CNT_W    = 13
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_param,
    input  logic [1:0]  cmd_source,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    input  logic        upd_busy,
    input  logic [31:0] upd_data_out,
    output logic [2:0]  upd_param,
    output logic [1:0]  upd_read_source,
    output logic [31:0] upd_data_in,
    output logic        upd_read_param,
    output logic        upd_write_param,
    output logic        upd_reconfig,
    output logic        upd_reset_timer,
    output logic        upd_reset
);
    import sys_update_pkg::*;

    localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

    state_e           state;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rst_s0;

    assign cnt_nxt   = cnt + CNT_W'(1);
    assign cmd_ready = (state == IDLE) && !upd_reset;

    // Two-flop reset release: the IP is held in reset until the second edge after reset_n rises.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_s0    <= 1'b0;
            upd_reset <= 1'b1;
        end else begin
            rst_s0    <= 1'b1;
            upd_reset <= ~rst_s0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            op_q            <= OP_RD;
            cnt             <= '0;
            upd_param       <= '0;
            upd_read_source <= '0;
            upd_data_in     <= '0;
            upd_read_param  <= 1'b0;
            upd_write_param <= 1'b0;
            upd_reconfig    <= 1'b0;
            upd_reset_timer <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_error       <= 1'b0;
            rsp_rdata       <= '0;
        end else begin
            upd_read_param  <= 1'b0;
            upd_write_param <= 1'b0;
            upd_reconfig    <= 1'b0;
            upd_reset_timer <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_error       <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        upd_param       <= cmd_param;
                        upd_read_source <= cmd_source;
                        upd_data_in     <= cmd_wdata;
                        op_q            <= op_e'(cmd_op);
                        // Strobes are registered so they are high exactly for the ISSUE cycle.
                        case (op_e'(cmd_op))
                            OP_RD:    upd_read_param  <= 1'b1;
                            OP_WR:    upd_write_param <= 1'b1;
                            OP_RECFG: upd_reconfig    <= 1'b1;
                            default:  upd_reset_timer <= 1'b1;
                        endcase
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                    if (op_q == OP_KICK) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt_nxt;
                    // Busy is only trusted once the IP has had MIN_WAIT cycles to raise it; success beats timeout.
                    if ((cnt_nxt >= MIN_WAIT_C) && !upd_busy) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        if (op_q == OP_RD) begin
                            rsp_rdata <= upd_data_out;
                        end
                    end else if (cnt_nxt >= TIMEOUT_C) begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_update_ctrl.sv
// Self-checking bench for sys_update_ctrl: directed scenarios plus randomized commands against a
// cycle-count reference model; a small update-IP model supplies busy and read data.
module tb_sys_update_ctrl;

    localparam int MIN_WAIT = 2;
    localparam int TIMEOUT  = 4096;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [2:0]  cmd_param = '0;
    logic [1:0]  cmd_source = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        upd_busy = 1'b0;
    logic [31:0] upd_data_out;
    logic [2:0]  upd_param;
    logic [1:0]  upd_read_source;
    logic [31:0] upd_data_in;
    logic        upd_read_param;
    logic        upd_write_param;
    logic        upd_reconfig;
    logic        upd_reset_timer;
    logic        upd_reset;

    int n_checks = 0;
    int n_err    = 0;

    // Update IP storage (driven into the DUT) and the bench's own expectation of it.
    logic [31:0] ip_mem  [8] = '{32'h3, 32'hA5A5_0001, 32'h0000_0010, 32'h1,
                                 32'h0100_0000, 32'h2, 32'h0, 32'h0};
    logic [31:0] exp_mem [8] = '{32'h3, 32'hA5A5_0001, 32'h0000_0010, 32'h1,
                                 32'h0100_0000, 32'h2, 32'h0, 32'h0};
    logic [31:0] exp_rdata = '0;

    always #5 clock = ~clock;

    assign upd_data_out = ip_mem[upd_param];
    always @(posedge clock) begin
        if (upd_write_param) ip_mem[upd_param] <= upd_data_in;
    end

    sys_update_ctrl #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT), .CNT_W(13)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_param(cmd_param), .cmd_source(cmd_source), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .upd_busy(upd_busy), .upd_data_out(upd_data_out), .upd_param(upd_param),
        .upd_read_source(upd_read_source), .upd_data_in(upd_data_in),
        .upd_read_param(upd_read_param), .upd_write_param(upd_write_param),
        .upd_reconfig(upd_reconfig), .upd_reset_timer(upd_reset_timer),
        .upd_reset(upd_reset)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("ready_wait", cmd_ready, 1);
    endtask

    // Issue one command; busy is high for b cycles starting the cycle after the strobe.
    // Cycle numbering: accept cycle = 0, strobe cycle = 1.
    task automatic run_cmd(input int op, input logic [2:0] prm, input logic [1:0] src,
                           input logic [31:0] wd, input int b);
        int c, got_c, exp_c, fc;
        int sc[4];
        logic got_err, exp_err, bad_cyc, stable_ok;
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'(op); cmd_param = prm; cmd_source = src; cmd_wdata = wd;
        upd_busy = 1'b0;
        @(negedge clock);
        cmd_valid = 1'b0;
        c = 1; got_c = -1; got_err = 1'b0; bad_cyc = 1'b0; stable_ok = 1'b1;
        sc = '{default: 0};
        while (c <= TIMEOUT + 8) begin
            if (upd_read_param)  sc[0]++;
            if (upd_write_param) sc[1]++;
            if (upd_reconfig)    sc[2]++;
            if (upd_reset_timer) sc[3]++;
            if ((upd_read_param | upd_write_param | upd_reconfig | upd_reset_timer) && c != 1)
                bad_cyc = 1'b1;
            if (upd_param !== prm || upd_read_source !== src || upd_data_in !== wd)
                stable_ok = 1'b0;
            if (rsp_valid) begin
                got_c = c;
                got_err = rsp_error;
                break;
            end
            upd_busy = (c >= 2 && c <= b + 1);
            @(negedge clock);
            c++;
        end
        upd_busy = 1'b0;
        // Reference: busy first sampled MIN_WAIT cycles after the strobe; response one cycle after the deciding cycle.
        if (op == 3) begin
            exp_c = 2; exp_err = 1'b0;
        end else begin
            fc = (b + 2 > 1 + MIN_WAIT) ? b + 2 : 1 + MIN_WAIT;
            if (fc > TIMEOUT + 1) begin
                exp_c = TIMEOUT + 2; exp_err = 1'b1;
            end else begin
                exp_c = fc + 1; exp_err = 1'b0;
            end
        end
        check($sformatf("latency_op%0d_b%0d", op, b), got_c, exp_c);
        check("rsp_error", got_err, exp_err);
        for (int k = 0; k < 4; k++) check($sformatf("strobe_count_%0d", k), sc[k], (k == op) ? 1 : 0);
        check("strobe_outside_issue", bad_cyc, 0);
        check("fields_stable", stable_ok, 1);
        if (op == 0 && !exp_err) exp_rdata = exp_mem[prm];
        if (op == 1) exp_mem[prm] = wd;
        @(negedge clock);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("ready_after_done", cmd_ready, 1);
        check("rsp_valid_single", rsp_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, nr, s1, s2;
        repeat (3) @(negedge clock);
        check("rst_upd_reset", upd_reset, 1);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", {rsp_valid, rsp_error}, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_upd_fields", {upd_param, upd_read_source}, 0);
        check("rst_upd_data_in", upd_data_in, 0);
        check("rst_strobes", {upd_read_param, upd_write_param, upd_reconfig, upd_reset_timer}, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rel_edge1_upd_reset", upd_reset, 1);
        check("rel_edge1_cmd_ready", cmd_ready, 0);
        @(negedge clock);
        check("rel_edge2_upd_reset", upd_reset, 0);
        check("rel_edge2_cmd_ready", cmd_ready, 1);

        run_cmd(0, 3'h0, 2'd0, 32'h0, 0);
        run_cmd(0, 3'h4, 2'd1, 32'h0, 0);
        run_cmd(1, 3'h4, 2'd0, 32'h0020_0000, 0);
        run_cmd(0, 3'h0, 2'd2, 32'h0, 10);
        run_cmd(0, 3'h2, 2'd0, 32'h0, 5000);
        run_cmd(3, 3'h1, 2'd0, 32'h0, 0);
        run_cmd(2, 3'h4, 2'd0, 32'h0, 0);
        run_cmd(1, 3'h3, 2'd3, 32'hCAFE_0042, 3);
        run_cmd(0, 3'h3, 2'd0, 32'h0, 1);

        // cmd_valid held high: the second kick may only be taken after the first DONE.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_param = 3'h3;
        ns = 0; nr = 0; s1 = -1; s2 = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (upd_reset_timer) begin
                ns++;
                if (ns == 1) s1 = c; else s2 = c;
            end
            if (rsp_valid) nr++;
            if (c == 4) cmd_valid = 1'b0;
        end
        check("hold_strobe_count", ns, 2);
        check("hold_first_strobe", s1, 1);
        check("hold_second_strobe", s2, 4);
        check("hold_rsp_count", nr, 2);

        // Reset during WAIT aborts with no response.
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_param = 3'h4; cmd_source = 2'd1;
        cmd_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        cmd_valid = 1'b0; upd_busy = 1'b1; nr = 0;
        repeat (5) begin
            @(negedge clock);
            if (rsp_valid) nr++;
        end
        #2 reset_n = 1'b0;
        #1;
        check("abort_upd_reset", upd_reset, 1);
        check("abort_cmd_ready", cmd_ready, 0);
        check("abort_rsp_rdata", rsp_rdata, 0);
        check("abort_upd_param", {upd_param, upd_read_source}, 0);
        check("abort_upd_data_in", upd_data_in, 0);
        repeat (2) begin
            @(negedge clock);
            if (rsp_valid) nr++;
        end
        reset_n = 1'b1; upd_busy = 1'b0;
        @(negedge clock);
        if (rsp_valid) nr++;
        check("abort_rel1_upd_reset", upd_reset, 1);
        @(negedge clock);
        if (rsp_valid) nr++;
        check("abort_rel2_upd_reset", upd_reset, 0);
        check("abort_rel2_cmd_ready", cmd_ready, 1);
        check("abort_no_rsp", nr, 0);
        exp_rdata = '0;

        for (int i = 0; i < 24; i++) begin
            run_cmd(int'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    $urandom, int'($urandom_range(0, 12)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
